// File: rtl/reg_file_rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_rename_pkg
//  Description : Shared widths and constants for the architectural register
//                file / rename table and its dispatcher/ROB interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_rename_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // x0 is hardwired to zero; tag 0 means "no in-flight producer".
    localparam logic [REG_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [ROB_WIDTH-1:0] NO_TAG   = '0;

    // Only non-zero architectural registers can hold state.
    function automatic logic reg_writable(input logic [REG_WIDTH-1:0] idx);
        return (idx != ZERO_REG);
    endfunction

endpackage : reg_file_rename_pkg
`default_nettype wire

// File: rtl/reg_file_rename_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_rename_if
//  Description : Dispatcher rename/lookup and ROB commit/refresh signals seen
//                by the register file. master = dispatcher+ROB side,
//                slave = register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_rename_if;
    import reg_file_rename_pkg::*;

    // dispatcher rename
    logic                  rdy_dp_in;
    logic [REG_WIDTH-1:0]  dest_dp_in;
    logic [ROB_WIDTH-1:0]  rob_id_dp_in;
    // dispatcher source lookup
    logic [REG_WIDTH-1:0]  rs1_dp_in;
    logic [REG_WIDTH-1:0]  rs2_dp_in;
    logic                  rs1_busy_dp_out;
    logic [ROB_WIDTH-1:0]  rs1_rob_dp_out;
    logic [DATA_WIDTH-1:0] rs1_val_dp_out;
    logic                  rs2_busy_dp_out;
    logic [ROB_WIDTH-1:0]  rs2_rob_dp_out;
    logic [DATA_WIDTH-1:0] rs2_val_dp_out;
    // ROB commit and flush
    logic                  rdy_commit_rob_in;
    logic [REG_WIDTH-1:0]  dest_rob_in;
    logic [DATA_WIDTH-1:0] value_rob_in;
    logic [ROB_WIDTH-1:0]  rob_id_rob_in;
    logic                  refresh_in;

    modport master (
        output rdy_dp_in, dest_dp_in, rob_id_dp_in, rs1_dp_in, rs2_dp_in,
        output rdy_commit_rob_in, dest_rob_in, value_rob_in, rob_id_rob_in,
        output refresh_in,
        input  rs1_busy_dp_out, rs1_rob_dp_out, rs1_val_dp_out,
        input  rs2_busy_dp_out, rs2_rob_dp_out, rs2_val_dp_out
    );

    modport slave (
        input  rdy_dp_in, dest_dp_in, rob_id_dp_in, rs1_dp_in, rs2_dp_in,
        input  rdy_commit_rob_in, dest_rob_in, value_rob_in, rob_id_rob_in,
        input  refresh_in,
        output rs1_busy_dp_out, rs1_rob_dp_out, rs1_val_dp_out,
        output rs2_busy_dp_out, rs2_rob_dp_out, rs2_val_dp_out
    );

endinterface : reg_file_rename_if
`default_nettype wire

// File: rtl/reg_file_rename_rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_rename_rf_read_port
//  Description : Combinational source-operand lookup (rf_read_port). Returns
//                value or producing ROB tag, with bypass of a same-cycle
//                commit from the tag that currently owns the register.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rename_rf_read_port
    import reg_file_rename_pkg::*;
(
    input  wire logic [REG_WIDTH-1:0]  rs_in,
    input  wire logic [DATA_WIDTH-1:0] value_arr_in [REG_NUM],
    input  wire logic                  busy_arr_in  [REG_NUM],
    input  wire logic [ROB_WIDTH-1:0]  tag_arr_in   [REG_NUM],
    input  wire logic                  rdy_commit_in,
    input  wire logic [REG_WIDTH-1:0]  dest_commit_in,
    input  wire logic [DATA_WIDTH-1:0] value_commit_in,
    input  wire logic [ROB_WIDTH-1:0]  rob_id_commit_in,
    output logic                       busy_out,
    output logic [ROB_WIDTH-1:0]       rob_out,
    output logic [DATA_WIDTH-1:0]      val_out
);

    logic                  w_busy;
    logic [ROB_WIDTH-1:0]  w_tag;
    logic [DATA_WIDTH-1:0] w_value;
    logic                  w_bypass;

    assign w_busy  = busy_arr_in[rs_in];
    assign w_tag   = tag_arr_in[rs_in];
    assign w_value = value_arr_in[rs_in];

    // A commit only resolves the operand if it comes from the current owner;
    // a stale commit (register renamed again since) must not be forwarded.
    assign w_bypass = w_busy && rdy_commit_in && (dest_commit_in == rs_in) &&
                      (rob_id_commit_in == w_tag);

    // Priority lookup: x0, commit bypass, in-flight producer, stored value.
    always_comb begin
        busy_out = FALSE;
        rob_out  = NO_TAG;
        val_out  = '0;
        if (!reg_writable(rs_in)) begin
            busy_out = FALSE;
            rob_out  = NO_TAG;
            val_out  = '0;
        end else if (w_bypass) begin
            busy_out = FALSE;
            rob_out  = NO_TAG;
            val_out  = value_commit_in;
        end else if (w_busy) begin
            busy_out = TRUE;
            rob_out  = w_tag;
            val_out  = w_value;
        end else begin
            busy_out = FALSE;
            rob_out  = NO_TAG;
            val_out  = w_value;
        end
    end

endmodule : reg_file_rename_rf_read_port
`default_nettype wire

// File: rtl/reg_file_rename.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_rename
//  Description : Architectural register file plus rename table. Receives
//                renames from the dispatcher and in-order commits from the
//                ROB; answers two source lookups per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    input  wire logic          rdy_in,
    reg_file_rename_if.slave   bus
);

    logic [DATA_WIDTH-1:0] r_value [REG_NUM];
    logic                  r_busy  [REG_NUM];
    logic [ROB_WIDTH-1:0]  r_tag   [REG_NUM];

    logic w_commit_en;
    logic w_rename_en;

    assign w_commit_en = bus.rdy_commit_rob_in && reg_writable(bus.dest_rob_in);
    assign w_rename_en = bus.rdy_dp_in && reg_writable(bus.dest_dp_in) && !bus.refresh_in;

    // State update: commit, then rename, then refresh; later non-blocking
    // assignments override earlier ones so the priority falls out naturally.
    // Refresh clears ownership only, so a commit in the flush cycle still lands.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_busy[i]  <= FALSE;
                r_tag[i]   <= NO_TAG;
            end
        end else if (rdy_in) begin
            if (w_commit_en) begin
                r_value[bus.dest_rob_in] <= bus.value_rob_in;
                if (r_tag[bus.dest_rob_in] == bus.rob_id_rob_in) begin
                    r_busy[bus.dest_rob_in] <= FALSE;
                    r_tag[bus.dest_rob_in]  <= NO_TAG;
                end
            end
            if (w_rename_en) begin
                r_busy[bus.dest_dp_in] <= TRUE;
                r_tag[bus.dest_dp_in]  <= bus.rob_id_dp_in;
            end
            if (bus.refresh_in) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    r_busy[i] <= FALSE;
                    r_tag[i]  <= NO_TAG;
                end
            end
        end
    end

    reg_file_rename_rf_read_port u_rs1_port (
        .rs_in            (bus.rs1_dp_in),
        .value_arr_in     (r_value),
        .busy_arr_in      (r_busy),
        .tag_arr_in       (r_tag),
        .rdy_commit_in    (bus.rdy_commit_rob_in),
        .dest_commit_in   (bus.dest_rob_in),
        .value_commit_in  (bus.value_rob_in),
        .rob_id_commit_in (bus.rob_id_rob_in),
        .busy_out         (bus.rs1_busy_dp_out),
        .rob_out          (bus.rs1_rob_dp_out),
        .val_out          (bus.rs1_val_dp_out)
    );

    reg_file_rename_rf_read_port u_rs2_port (
        .rs_in            (bus.rs2_dp_in),
        .value_arr_in     (r_value),
        .busy_arr_in      (r_busy),
        .tag_arr_in       (r_tag),
        .rdy_commit_in    (bus.rdy_commit_rob_in),
        .dest_commit_in   (bus.dest_rob_in),
        .value_commit_in  (bus.value_rob_in),
        .rob_id_commit_in (bus.rob_id_rob_in),
        .busy_out         (bus.rs2_busy_dp_out),
        .rob_out          (bus.rs2_rob_dp_out),
        .val_out          (bus.rs2_val_dp_out)
    );

endmodule : reg_file_rename
`default_nettype wire

// File: tb/tb_reg_file_rename.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_rename
//  Description : Directed self-checking bench for reg_file_rename. Inputs
//                change 1ns after the rising edge; outputs are sampled 1ns
//                later, well away from the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_rename;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    int checks = 0;
    int errors = 0;

    logic [36:0] obs;

    reg_file_rename_if bus ();

    reg_file_rename u_dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [36:0] rs1_obs();
        return {bus.rs1_busy_dp_out, bus.rs1_rob_dp_out, bus.rs1_val_dp_out};
    endfunction

    function automatic logic [36:0] rs2_obs();
        return {bus.rs2_busy_dp_out, bus.rs2_rob_dp_out, bus.rs2_val_dp_out};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.rdy_dp_in         = 1'b0;
        bus.dest_dp_in        = '0;
        bus.rob_id_dp_in      = '0;
        bus.rdy_commit_rob_in = 1'b0;
        bus.dest_rob_in       = '0;
        bus.value_rob_in      = '0;
        bus.rob_id_rob_in     = '0;
        bus.refresh_in        = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] id);
        bus.rdy_dp_in    = 1'b1;
        bus.dest_dp_in   = rd;
        bus.rob_id_dp_in = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] id);
        bus.rdy_commit_rob_in = 1'b1;
        bus.dest_rob_in       = rd;
        bus.value_rob_in      = v;
        bus.rob_id_rob_in     = id;
    endtask

    task automatic test_reset();
        idle();
        bus.rs1_dp_in = 5'd5;
        bus.rs2_dp_in = 5'd0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h0}) begin errors++; $display("FAIL reset_rs1: got %h expected %h", obs, {1'b0, 4'd0, 32'h0}); end
        obs = rs2_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h0}) begin errors++; $display("FAIL reset_rs2: got %h expected %h", obs, {1'b0, 4'd0, 32'h0}); end
    endtask

    task automatic test_commit_bypass();
        tick();
        rename(5'd3, 4'd2);
        tick();
        idle();
        bus.rs1_dp_in = 5'd3;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b1, 4'd2, 32'h0}) begin errors++; $display("FAIL rename_x3_busy: got %h expected %h", obs, {1'b1, 4'd2, 32'h0}); end
        commit(5'd3, 32'h1234, 4'd2);
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h1234}) begin errors++; $display("FAIL commit_bypass: got %h expected %h", obs, {1'b0, 4'd0, 32'h1234}); end
        tick();
        idle();
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h1234}) begin errors++; $display("FAIL commit_stored: got %h expected %h", obs, {1'b0, 4'd0, 32'h1234}); end
    endtask

    task automatic test_stale_commit();
        rename(5'd3, 4'd2);
        tick();
        rename(5'd3, 4'd5);
        tick();
        idle();
        commit(5'd3, 32'd7, 4'd2);
        bus.rs1_dp_in = 5'd3;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b1, 4'd5, 32'h1234}) begin errors++; $display("FAIL stale_no_bypass: got %h expected %h", obs, {1'b1, 4'd5, 32'h1234}); end
        tick();
        idle();
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b1, 4'd5, 32'd7}) begin errors++; $display("FAIL stale_keeps_busy: got %h expected %h", obs, {1'b1, 4'd5, 32'd7}); end
        commit(5'd3, 32'd9, 4'd5);
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'd9}) begin errors++; $display("FAIL owner_bypass: got %h expected %h", obs, {1'b0, 4'd0, 32'd9}); end
        tick();
        idle();
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'd9}) begin errors++; $display("FAIL owner_commit: got %h expected %h", obs, {1'b0, 4'd0, 32'd9}); end
    endtask

    task automatic test_rename_beats_commit();
        rename(5'd4, 4'd1);
        tick();
        idle();
        commit(5'd4, 32'hAA, 4'd1);
        rename(5'd4, 4'd6);
        bus.rs1_dp_in = 5'd4;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'hAA}) begin errors++; $display("FAIL read_pre_rename: got %h expected %h", obs, {1'b0, 4'd0, 32'hAA}); end
        tick();
        idle();
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b1, 4'd6, 32'hAA}) begin errors++; $display("FAIL rename_beats_commit: got %h expected %h", obs, {1'b1, 4'd6, 32'hAA}); end
    endtask

    task automatic test_refresh();
        commit(5'd1, 32'h11, 4'd7);
        tick();
        commit(5'd2, 32'h22, 4'd7);
        tick();
        idle();
        rename(5'd1, 4'd3);
        tick();
        rename(5'd2, 4'd4);
        tick();
        idle();
        bus.rs1_dp_in = 5'd1;
        bus.rs2_dp_in = 5'd2;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b1, 4'd3, 32'h11}) begin errors++; $display("FAIL pre_refresh_x1: got %h expected %h", obs, {1'b1, 4'd3, 32'h11}); end
        obs = rs2_obs(); checks++;
        if (obs !== {1'b1, 4'd4, 32'h22}) begin errors++; $display("FAIL pre_refresh_x2: got %h expected %h", obs, {1'b1, 4'd4, 32'h22}); end
        bus.refresh_in = 1'b1;
        commit(5'd7, 32'h55, 4'd1);
        rename(5'd5, 4'd9);
        tick();
        idle();
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h11}) begin errors++; $display("FAIL refresh_x1: got %h expected %h", obs, {1'b0, 4'd0, 32'h11}); end
        obs = rs2_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h22}) begin errors++; $display("FAIL refresh_x2: got %h expected %h", obs, {1'b0, 4'd0, 32'h22}); end
        bus.rs1_dp_in = 5'd7;
        bus.rs2_dp_in = 5'd5;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h55}) begin errors++; $display("FAIL refresh_commit_lands: got %h expected %h", obs, {1'b0, 4'd0, 32'h55}); end
        obs = rs2_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h0}) begin errors++; $display("FAIL refresh_rename_ignored: got %h expected %h", obs, {1'b0, 4'd0, 32'h0}); end
        bus.rs1_dp_in = 5'd4;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'hAA}) begin errors++; $display("FAIL refresh_x4: got %h expected %h", obs, {1'b0, 4'd0, 32'hAA}); end
    endtask

    task automatic test_x0_and_hold();
        commit(5'd0, 32'hFFFF, 4'd0);
        rename(5'd0, 4'd3);
        bus.rs1_dp_in = 5'd0;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h0}) begin errors++; $display("FAIL x0_read_during_write: got %h expected %h", obs, {1'b0, 4'd0, 32'h0}); end
        tick();
        idle();
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h0}) begin errors++; $display("FAIL x0_after_write: got %h expected %h", obs, {1'b0, 4'd0, 32'h0}); end
        rdy_in = 1'b0;
        rename(5'd6, 4'd8);
        commit(5'd7, 32'h66, 4'd2);
        tick();
        tick();
        rdy_in = 1'b1;
        idle();
        bus.rs1_dp_in = 5'd6;
        bus.rs2_dp_in = 5'd7;
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h0}) begin errors++; $display("FAIL hold_no_rename: got %h expected %h", obs, {1'b0, 4'd0, 32'h0}); end
        obs = rs2_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h55}) begin errors++; $display("FAIL hold_no_commit: got %h expected %h", obs, {1'b0, 4'd0, 32'h55}); end
    endtask

    task automatic test_back_to_back();
        // rename x8 and x9 on consecutive cycles; commit x8 while renaming x9
        rename(5'd8, 4'd10);
        tick();
        idle();
        rename(5'd9, 4'd11);
        commit(5'd8, 32'hBEEF, 4'd10);
        bus.rs1_dp_in = 5'd8;
        bus.rs2_dp_in = 5'd9;
        #1;
        obs = rs2_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'h0}) begin errors++; $display("FAIL b2b_rs2_pre_rename: got %h expected %h", obs, {1'b0, 4'd0, 32'h0}); end
        tick();
        idle();
        commit(5'd9, 32'hCAFE, 4'd11);
        #1;
        obs = rs1_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'hBEEF}) begin errors++; $display("FAIL b2b_x8: got %h expected %h", obs, {1'b0, 4'd0, 32'hBEEF}); end
        obs = rs2_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'hCAFE}) begin errors++; $display("FAIL b2b_x9_bypass: got %h expected %h", obs, {1'b0, 4'd0, 32'hCAFE}); end
        tick();
        idle();
        #1;
        obs = rs2_obs(); checks++;
        if (obs !== {1'b0, 4'd0, 32'hCAFE}) begin errors++; $display("FAIL b2b_x9_stored: got %h expected %h", obs, {1'b0, 4'd0, 32'hCAFE}); end
    endtask

    initial begin
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        bus.rs1_dp_in = '0;
        bus.rs2_dp_in = '0;
        idle();
        test_reset();
        test_commit_bypass();
        test_stale_commit();
        test_rename_beats_commit();
        test_refresh();
        test_x0_and_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_rename
`default_nettype wire
